// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: fills a single-port RAM with an address-derived pattern, reads it back and reports mismatches
module ram_bist_ctrl #(
  parameter int WORD = 8,
  parameter int ADDR = 8,
  parameter int MEMS = 256,
  parameter int SEED = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [WORD-1:0] ram_do,
  output logic [ADDR-1:0] ram_ad,
  output logic [WORD-1:0] ram_di,
  output logic            ram_w,
  output logic            ram_cs,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ADDR:0]   err_cnt,
  output logic [ADDR-1:0] fail_addr,
  output logic [WORD-1:0] fail_data
);
  localparam logic [ADDR-1:0] LAST    = ADDR'(MEMS - 1);
  localparam logic [ADDR:0]   MAX_ERR = (ADDR + 1)'(MEMS);
  localparam logic [WORD-1:0] SEED_W  = WORD'(SEED);
  typedef enum logic [2:0] {IDLE, WRITE, WGAP, READ, DONE} state_t;
  state_t          state;
  logic [ADDR-1:0] addr, addr_nxt;
  logic [WORD-1:0] exp_data;
  logic            miss;
  assign addr_nxt = addr + 1'b1;
  assign exp_data = WORD'(addr) + SEED_W;
  assign miss     = ram_do != exp_data;
  assign pass     = done && err_cnt == '0;
  // outputs are registered with the values of the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      ram_ad    <= '0;
      ram_di    <= '0;
      ram_w     <= 1'b0;
      ram_cs    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          err_cnt   <= '0;
          fail_addr <= '0;
          fail_data <= '0;
          done      <= 1'b0;
          busy      <= 1'b1;
          addr      <= '0;
          ram_ad    <= '0;
          ram_di    <= SEED_W;
          ram_cs    <= 1'b1;
          ram_w     <= !mode;
          state     <= mode ? READ : WRITE;
        end
        WRITE: begin
          ram_w  <= 1'b0;
          ram_cs <= 1'b0;
          state  <= WGAP;
        end
        WGAP: if (addr == LAST) begin
          addr   <= '0;
          ram_ad <= '0;
          ram_cs <= 1'b1;
          state  <= READ;
        end else begin
          addr   <= addr_nxt;
          ram_ad <= addr_nxt;
          ram_di <= WORD'(addr_nxt) + SEED_W;
          ram_w  <= 1'b1;
          ram_cs <= 1'b1;
          state  <= WRITE;
        end
        READ: begin
          if (miss) begin
            if (err_cnt != MAX_ERR) err_cnt <= err_cnt + 1'b1;
            if (err_cnt == '0) begin
              fail_addr <= addr;
              fail_data <= ram_do;
            end
          end
          if (addr == LAST) begin
            ram_cs <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            addr   <= addr_nxt;
            ram_ad <= addr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
